ceyloniac_instruction_queue: RTL and testbench

Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction prefetch queue between instruction memory and the control unit. Fetched words enter through a valid/ready handshake, are buffered in FIFO order, and the head entry is presented pre-split into MIPS-style fields plus a sign-extended immediate. A flush input discards all buffered instructions on branch/jump redirect.

---
 rtl/ceyloniac_ir_pkg.sv | 16 +
 rtl/ceyloniac_instr_field_decode.sv | 49 ++++
 rtl/ceyloniac_instruction_queue.sv | 112 +++++++++++
 tb/tb_ceyloniac_instruction_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ceyloniac_ir_pkg.sv
// Shared constants for the ceyloniac instruction word layout (MIPS-style).
// Bit positions are absolute indices into a 32-bit instruction word.
package ceyloniac_ir_pkg;

   localparam int OPCODE_MSB = 31;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int IMM_MSB    = 15;
   localparam int TARGET_MSB = 25;
   localparam int IMM_WIDTH  = 16;

endpackage

// File: rtl/ceyloniac_instr_field_decode.sv
// Combinational instruction field slicer with immediate sign extension.
// Ports:
//   en           - when low every output is forced to zero
//   word         - instruction word to split
//   instr_31_26  - opcode
//   instr_25_21  - rs
//   instr_20_16  - rt
//   instr_15_11  - rd
//   instr_15_0   - immediate
//   instr_25_0   - jump target
//   imm_sext     - immediate sign-extended to RAM_DATA_WIDTH
module ceyloniac_instr_field_decode
   import ceyloniac_ir_pkg::*;
#(
   parameter int RAM_DATA_WIDTH = 32,
   parameter int OPCODE_WIDTH   = 6
) (
   input  logic                      en,
   input  logic [RAM_DATA_WIDTH-1:0] word,
   output logic [OPCODE_WIDTH-1:0]   instr_31_26,
   output logic [4:0]                instr_25_21,
   output logic [4:0]                instr_20_16,
   output logic [4:0]                instr_15_11,
   output logic [IMM_WIDTH-1:0]      instr_15_0,
   output logic [25:0]               instr_25_0,
   output logic [RAM_DATA_WIDTH-1:0] imm_sext
);

   always_comb begin
      instr_31_26 = '0;
      instr_25_21 = '0;
      instr_20_16 = '0;
      instr_15_11 = '0;
      instr_15_0  = '0;
      instr_25_0  = '0;
      imm_sext    = '0;
      if (en) begin
         instr_31_26 = word[OPCODE_MSB -: OPCODE_WIDTH];
         instr_25_21 = word[RS_MSB:RS_LSB];
         instr_20_16 = word[RT_MSB:RT_LSB];
         instr_15_11 = word[RD_MSB:RD_LSB];
         instr_15_0  = word[IMM_MSB -: IMM_WIDTH];
         instr_25_0  = word[TARGET_MSB:0];
         imm_sext    = {{(RAM_DATA_WIDTH-IMM_WIDTH){word[IMM_MSB]}},
                        word[IMM_MSB -: IMM_WIDTH]};
      end
   end

endmodule

// File: rtl/ceyloniac_instruction_queue.sv
// DEPTH-entry instruction prefetch FIFO between instruction memory and the
// control unit. The head entry is presented already split into fields.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   flush          - drop every buffered entry at the next edge
//   in_valid/in_ready, instruction - fetch side handshake and word
//   out_valid/out_ready            - consumer side handshake on the head
//   instr_* / imm_sext             - decoded head fields, zero when empty
//   count                          - entries held, 0..DEPTH
module ceyloniac_instruction_queue
   import ceyloniac_ir_pkg::*;
#(
   parameter int RAM_DATA_WIDTH = 32,
   parameter int OPCODE_WIDTH   = 6,
   parameter int DEPTH          = 4,
   parameter int PTR_WIDTH      = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [RAM_DATA_WIDTH-1:0] instruction,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OPCODE_WIDTH-1:0]   instr_31_26,
   output logic [4:0]                instr_25_21,
   output logic [4:0]                instr_20_16,
   output logic [4:0]                instr_15_11,
   output logic [IMM_WIDTH-1:0]      instr_15_0,
   output logic [25:0]               instr_25_0,
   output logic [RAM_DATA_WIDTH-1:0] imm_sext,
   output logic [PTR_WIDTH:0]        count
);

   localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

   logic [RAM_DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [RAM_DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]        count_q, count_d;
   logic                      push, pop;

   // No pass-through when full: a pop this cycle does not free a slot
   // until the next edge, which keeps in_ready free of out_ready.
   assign in_ready  = (count_q != FULL_CNT) && !flush;
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = instruction;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never cleared; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   ceyloniac_instr_field_decode #(
      .RAM_DATA_WIDTH (RAM_DATA_WIDTH),
      .OPCODE_WIDTH   (OPCODE_WIDTH)
   ) u_head_decode (
      .en          (out_valid),
      .word        (mem_q[rd_ptr_q]),
      .instr_31_26 (instr_31_26),
      .instr_25_21 (instr_25_21),
      .instr_20_16 (instr_20_16),
      .instr_15_11 (instr_15_11),
      .instr_15_0  (instr_15_0),
      .instr_25_0  (instr_25_0),
      .imm_sext    (imm_sext)
   );

endmodule

// File: tb/tb_ceyloniac_instruction_queue.sv
module tb_ceyloniac_instruction_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instruction = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  instr_31_26;
   logic [4:0]  instr_25_21, instr_20_16, instr_15_11;
   logic [15:0] instr_15_0;
   logic [25:0] instr_25_0;
   logic [31:0] imm_sext;
   logic [2:0]  count;

   ceyloniac_instruction_queue #(
      .RAM_DATA_WIDTH (32),
      .OPCODE_WIDTH   (6),
      .DEPTH          (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .instr_31_26 (instr_31_26),
      .instr_25_21 (instr_25_21),
      .instr_20_16 (instr_20_16),
      .instr_15_11 (instr_15_11),
      .instr_15_0  (instr_15_0),
      .instr_25_0  (instr_25_0),
      .imm_sext    (imm_sext),
      .count       (count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: the queue contents as a plain list of words.
   logic [31:0] exp_q[$];
   bit          model_ok = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor at the falling edge: outputs settled from the last rising edge,
   // inputs for the coming edge already driven.
   always @(negedge clk) begin
      logic [31:0] h;
      logic [31:0] w;
      bit          has;
      if (model_ok) begin
         has = exp_q.size() != 0;
         h   = has ? exp_q[0] : 32'h0;
         chk("count", 32'(count), 32'(exp_q.size()));
         chk("out_valid", 32'(out_valid), 32'(has));
         chk("in_ready", 32'(in_ready), 32'((exp_q.size() < DEPTH) && !flush));
         chk("opcode", 32'(instr_31_26), h / 32'h0400_0000);
         chk("rs", 32'(instr_25_21), (h / 32'h0020_0000) % 32);
         chk("rt", 32'(instr_20_16), (h / 32'h0001_0000) % 32);
         chk("rd", 32'(instr_15_11), (h / 32'h0000_0800) % 32);
         chk("imm", 32'(instr_15_0), h % 32'h1_0000);
         chk("target", 32'(instr_25_0), h % 32'h0400_0000);
         chk("imm_sext", imm_sext,
             (h % 32'h1_0000 >= 32'h8000) ? (h % 32'h1_0000) + 32'hFFFF_0000 : h % 32'h1_0000);
      end
      if (reset) begin
         exp_q.delete();
         model_ok = 1;
      end else if (model_ok) begin
         if (flush) begin
            exp_q.delete();
         end else begin
            has = exp_q.size() != 0;
            if (exp_q.size() < DEPTH && in_valid) begin
               exp_q.push_back(instruction);
            end
            if (has && out_ready) begin
               w = exp_q.pop_front();
               chk("pop_word", {instr_31_26, instr_25_0}, w);
            end
         end
      end
   end

   task automatic cyc(input logic iv, input logic [31:0] w, input logic ordy,
                      input logic fl, input logic rst);
      @(posedge clk);
      #1;
      in_valid    = iv;
      instruction = w;
      out_ready   = ordy;
      flush       = fl;
      reset       = rst;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      // reset held for two edges
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle(2);

      // single word with sign-extended negative immediate
      cyc(1'b1, 32'h8C22_FFFC, 1'b0, 1'b0, 1'b0);
      idle(2);
      drain();

      // fill, refused extra word, then in-order drain
      for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
      drain();

      // steady push+pop at count 2 across pointer wrap
      cyc(1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hA000_0002, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
      drain();

      // flush with 3 held while a word is offered
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
      idle(2);

      // full boundary: pop only, then the word is accepted next cycle
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h1234_8765, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h1234_8765, 1'b0, 1'b0, 1'b0);
      idle(1);
      drain();

      // randomized traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 79) == 0));
      end
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      drain();
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
